// File: rtl/eth_rx_buf_ctrl_if.sv
// Receive-buffer controller bus: receiver byte stream, registered RAM write port and host queue status/pop.
// The slave modport is the controller side; the master modport is the side that drives stream and pop.
interface eth_rx_buf_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int IDX_W  = 2
);
  logic [7:0]              s_tdata;
  logic                    s_tvalid;
  logic                    s_tlast;
  logic                    s_tuser;
  logic                    ram_we;
  logic [IDX_W+ADDR_W-1:0] ram_addr;
  logic [7:0]              ram_wdata;
  logic                    rx_avail;
  logic [IDX_W:0]          rx_count;
  logic [IDX_W-1:0]        rx_head_idx;
  logic [ADDR_W:0]         rx_len;
  logic                    rx_err;
  logic                    rx_pop;
  logic [15:0]             drop_cnt;
  logic [15:0]             bad_cnt;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, rx_pop,
    output ram_we, ram_addr, ram_wdata, rx_avail, rx_count, rx_head_idx,
           rx_len, rx_err, drop_cnt, bad_cnt
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser, rx_pop,
    input  ram_we, ram_addr, ram_wdata, rx_avail, rx_count, rx_head_idx,
           rx_len, rx_err, drop_cnt, bad_cnt
  );
endinterface

// File: rtl/eth_rx_buf_ctrl.sv
// Ethernet receive-buffer controller: writes frames into a ring of NBUF RAM slots and queues them for the host.
// Optional macro ETH_RX_KEEP_BAD_EN: commit bad frames with rx_err=1 instead of discarding them.
module eth_rx_buf_ctrl #(
  parameter int NBUF   = 4,
  parameter int ADDR_W = 11,
  parameter int IDX_W  = 2
) (
  input logic               clk,
  input logic               rst,
  eth_rx_buf_ctrl_if.slave  bus
);
  localparam logic [ADDR_W:0] LEN_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [IDX_W:0]  CNT_FULL = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t            state;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W:0]    count;
  logic [ADDR_W:0]   len;
  logic              commit_pend;
  logic [15:0]       drop_cnt;
  logic [15:0]       bad_cnt;
  logic              ram_we;
  logic [IDX_W+ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [ADDR_W:0]   stat_len [NBUF];
`ifdef ETH_RX_KEEP_BAD_EN
  logic              stat_err [NBUF];
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A commit retiring on this edge is not yet visible in wr_idx/count, so a
  // back-to-back frame start must look ahead to the post-commit slot and fill level.
  logic [IDX_W-1:0]  wr_eff;
  logic [IDX_W:0]    cnt_eff;
  logic              full;
  logic              take;
  logic              drop_ev;
  logic              pop_ok;
  logic              keep;
  logic [IDX_W-1:0]  wr_slot;
  logic [ADDR_W-1:0] wr_off;
  logic [ADDR_W:0]   len_next;

  always_comb begin
    wr_eff   = commit_pend ? wr_idx + IDX_W'(1) : wr_idx;
    cnt_eff  = count + {{IDX_W{1'b0}}, commit_pend};
    full     = (cnt_eff == CNT_FULL);
    take     = bus.s_tvalid && (((state == IDLE) && !full) ||
                                ((state == RECV) && (len != LEN_FULL)));
    drop_ev  = bus.s_tvalid && (((state == IDLE) && full) ||
                                ((state == RECV) && (len == LEN_FULL)));
    pop_ok   = bus.rx_pop && (count != '0);
    wr_slot  = (state == IDLE) ? wr_eff : wr_idx;
    wr_off   = (state == IDLE) ? '0 : len[ADDR_W-1:0];
    len_next = (state == IDLE) ? (ADDR_W+1)'(1) : len + (ADDR_W+1)'(1);
`ifdef ETH_RX_KEEP_BAD_EN
    keep     = 1'b1;
`else
    keep     = !bus.s_tuser;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_idx      <= '0;
      rd_idx      <= '0;
      count       <= '0;
      len         <= '0;
      commit_pend <= 1'b0;
      drop_cnt    <= '0;
      bad_cnt     <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      ram_we      <= 1'b0;
      commit_pend <= 1'b0;
      if (commit_pend) wr_idx <= wr_idx + IDX_W'(1);
      if (pop_ok)      rd_idx <= rd_idx + IDX_W'(1);
      case ({commit_pend, pop_ok})
        2'b10:   count <= count + (IDX_W+1)'(1);
        2'b01:   count <= count - (IDX_W+1)'(1);
        default: count <= count;
      endcase

      if (take) begin
        ram_we    <= 1'b1;
        ram_addr  <= {wr_slot, wr_off};
        ram_wdata <= bus.s_tdata;
        len       <= len_next;
        if (bus.s_tlast) commit_pend <= keep;
      end
      if (drop_ev) drop_cnt <= sat_inc(drop_cnt);
      if (bus.s_tvalid && bus.s_tlast && bus.s_tuser) bad_cnt <= sat_inc(bad_cnt);

      if (bus.s_tvalid) begin
        if (bus.s_tlast) state <= IDLE;
        else if (take)   state <= RECV;
        else             state <= DISCARD;
      end
    end
  end

  // Status is written with the last byte; the slot only becomes visible once count rises.
  always_ff @(posedge clk) begin
    if (take && bus.s_tlast) begin
      stat_len[wr_slot] <= len_next;
`ifdef ETH_RX_KEEP_BAD_EN
      stat_err[wr_slot] <= bus.s_tuser;
`endif
    end
  end

  assign bus.ram_we      = ram_we;
  assign bus.ram_addr    = ram_addr;
  assign bus.ram_wdata   = ram_wdata;
  assign bus.rx_avail    = (count != '0);
  assign bus.rx_count    = count;
  assign bus.rx_head_idx = rd_idx;
  assign bus.rx_len      = (count != '0) ? stat_len[rd_idx] : '0;
`ifdef ETH_RX_KEEP_BAD_EN
  assign bus.rx_err      = (count != '0) && stat_err[rd_idx];
`else
  assign bus.rx_err      = 1'b0;
`endif
  assign bus.drop_cnt    = drop_cnt;
  assign bus.bad_cnt     = bad_cnt;
endmodule
